// File: rtl/thermal_tx_modulator_if.sv
// Payload handshake bundle for thermal_tx_modulator.
//   s_valid : payload offered by the producer
//   s_ready : transmitter can accept a payload this cycle
//   s_data  : payload word, transmitted MSB first
// master = producer side, slave = transmitter side.
interface thermal_tx_modulator_if #(
  parameter int unsigned PAYLOAD_W = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic [PAYLOAD_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/thermal_tx_modulator.sv
// Thermal covert-channel transmitter. Frames each accepted payload word as
// {PREAMBLE, payload}, sends it MSB first as OOK or Manchester chips, then
// appends GUARD_CHIPS heater-off chips. Each chip keys the masked heater banks,
// which are toggling flop registers that dissipate power while active.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   enable         : run/pause; low freezes the frame and turns heaters off
//   mode           : 0 = OOK, 1 = Manchester (sampled at accept)
//   bit_period     : clock cycles per chip, 0 acts as 1 (sampled at accept)
//   bank_mask      : banks that carry the frame (sampled at accept)
//   s              : payload handshake (s_valid/s_ready/s_data)
//   heat_on        : registered per-bank heater-active flags
//   heater_tap     : MSB of each heater bank, keeps the banks alive in synthesis
//   busy, done     : frame in progress / one-cycle completion pulse
//   frames_sent    : completed-frame count, wraps
//   led            : {frames_sent[0], latched mode, current chip, busy}
module thermal_tx_modulator #(
  parameter int unsigned      HEATER_W    = 75,
  parameter int unsigned      BANKS       = 4,
  parameter int unsigned      PAYLOAD_W   = 16,
  parameter int unsigned      PERIOD_W    = 24,
  parameter int unsigned      PRE_W       = 8,
  parameter logic [PRE_W-1:0] PREAMBLE    = 8'hA5,
  parameter int unsigned      GUARD_CHIPS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [PERIOD_W-1:0]   bit_period,
  input  logic [BANKS-1:0]      bank_mask,
  thermal_tx_modulator_if.slave s,
  output logic [BANKS-1:0]      heat_on,
  output logic [BANKS-1:0]      heater_tap,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frames_sent,
  output logic [3:0]            led
);

  localparam int unsigned FRAME_W = PRE_W + PAYLOAD_W;
  localparam int unsigned MAX_A   = (PRE_W > PAYLOAD_W) ? PRE_W : PAYLOAD_W;
  localparam int unsigned MAX_CNT = (MAX_A > GUARD_CHIPS) ? MAX_A : GUARD_CHIPS;
  localparam int unsigned IDX_W   = $clog2(MAX_CNT + 1);

  localparam logic [IDX_W-1:0] PRE_LAST   = IDX_W'(PRE_W - 1);
  localparam logic [IDX_W-1:0] PAY_LAST   = IDX_W'(PAYLOAD_W - 1);
  localparam logic [IDX_W-1:0] GUARD_LAST = IDX_W'(GUARD_CHIPS - 1);

  typedef enum logic [1:0] {StIdle, StPre, StData, StGuard} state_e;

  state_e                state_q, state_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [FRAME_W-1:0]    sh_q, sh_d;
  logic                  half_q, half_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  mode_q, mode_d;
  logic [BANKS-1:0]      mask_q, mask_d;
  logic [BANKS-1:0]      heat_on_q, heat_on_d;
  logic                  done_q, done_d;
  logic [15:0]           frames_q, frames_d;
  logic                  alive_q;

  logic                  s_ready_int;
  logic                  accept;
  logic                  chip_end;
  logic                  chip_q;
  logic                  chip_d;

  // alive_q keeps s_ready low until the first edge after reset release.
  assign s_ready_int = enable && alive_q && (state_q == StIdle);
  assign s.s_ready   = s_ready_int;
  assign accept      = s.s_valid && s_ready_int;
  assign chip_end    = (cnt_q == (period_q - 1'b1));

  // Manchester second half-bit sends the inverted bit.
  assign chip_q = ((state_q == StPre) || (state_q == StData)) &&
                  (sh_q[FRAME_W-1] ^ (mode_q && half_q));
  assign chip_d = ((state_d == StPre) || (state_d == StData)) &&
                  (sh_d[FRAME_W-1] ^ (mode_d && half_d));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    sh_d     = sh_q;
    half_d   = half_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
    frames_d = frames_q;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d  = StPre;
            cnt_d    = '0;
            period_d = (bit_period == '0) ? PERIOD_W'(1) : bit_period;
            sh_d     = {PREAMBLE, s.s_data};
            half_d   = 1'b0;
            idx_d    = '0;
            mode_d   = mode;
            mask_d   = bank_mask;
          end
        end
        StPre, StData: begin
          if (!chip_end) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (mode_q && !half_q) begin
              half_d = 1'b1;
            end else begin
              half_d = 1'b0;
              sh_d   = {sh_q[FRAME_W-2:0], 1'b0};
              if ((state_q == StPre) && (idx_q == PRE_LAST)) begin
                state_d = StData;
                idx_d   = '0;
              end else if ((state_q == StData) && (idx_q == PAY_LAST)) begin
                state_d = StGuard;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
        end
        StGuard: begin
          if (!chip_end) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (idx_q == GUARD_LAST) begin
              state_d  = StIdle;
              idx_d    = '0;
              done_d   = 1'b1;
              frames_d = frames_q + 16'd1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Heater flags track the chip that the next cycle will carry; paused cycles force off.
  always_comb begin
    heat_on_d = '0;
    if (enable && chip_d) begin
      heat_on_d = mask_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      period_q  <= '0;
      sh_q      <= '0;
      half_q    <= 1'b0;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      mask_q    <= '0;
      heat_on_q <= '0;
      done_q    <= 1'b0;
      frames_q  <= '0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      sh_q      <= sh_d;
      half_q    <= half_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      heat_on_q <= heat_on_d;
      done_q    <= done_d;
      frames_q  <= frames_d;
      alive_q   <= 1'b1;
    end
  end

  logic [HEATER_W-1:0] bank_q [BANKS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < BANKS; b++) begin
        bank_q[b] <= '0;
      end
    end else if (enable) begin
      for (int b = 0; b < BANKS; b++) begin
        if (heat_on_q[b]) begin
          bank_q[b] <= ~bank_q[b];
        end
      end
    end
  end

  always_comb begin
    heater_tap = '0;
    for (int b = 0; b < BANKS; b++) begin
      heater_tap[b] = bank_q[b][HEATER_W-1];
    end
  end

  assign heat_on     = heat_on_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign frames_sent = frames_q;
  assign led         = {frames_q[0], mode_q, chip_q, busy};

endmodule

// File: tb/tb_thermal_tx_modulator.sv
// Scoreboard bench for thermal_tx_modulator: the driver pushes a per-cycle
// expected heat_on/busy/done trace when a frame is accepted, and a negedge
// monitor pops and compares it whenever the DUT shows busy or done.
module tb_thermal_tx_modulator;
  localparam int unsigned BANKS     = 4;
  localparam int unsigned PAYLOAD_W = 16;
  localparam int unsigned PERIOD_W  = 24;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b1;
  logic                mode = 1'b0;
  logic [PERIOD_W-1:0] bit_period = '0;
  logic [BANKS-1:0]    bank_mask = '0;
  logic [BANKS-1:0]    heat_on;
  logic [BANKS-1:0]    heater_tap;
  logic                busy;
  logic                done;
  logic [15:0]         frames_sent;
  logic [3:0]          led;

  thermal_tx_modulator_if #(.PAYLOAD_W(PAYLOAD_W)) bus ();

  thermal_tx_modulator dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .bit_period  (bit_period),
    .bank_mask   (bank_mask),
    .s           (bus),
    .heat_on     (heat_on),
    .heater_tap  (heater_tap),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent),
    .led         (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  heat;
    logic        busy;
    logic        done;
    logic [15:0] frames;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         model_frames = 0;
  logic       en_edge = 1'b0;
  logic [3:0] prev_tap = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_edge <= enable;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (!en_edge) begin
        if (busy) begin
          chk("pause_heat_on", heat_on, 0);
          chk("pause_heater_tap", heater_tap, prev_tap);
        end
      end else if (busy || done) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: busy=%0b done=%0b with empty scoreboard at cycle %0d",
                   busy, done, cyc);
        end else begin
          e = sbq.pop_front();
          chk("heat_on", heat_on, e.heat);
          chk("busy", busy, e.busy);
          chk("done", done, e.done);
          if (e.done) chk("frames_sent", frames_sent, e.frames);
        end
      end else begin
        chk("idle_heat_on", heat_on, 0);
      end
    end
    prev_tap <= heater_tap;
  end

  // Expected trace: P cycles per chip, then guard chips, then the done cycle.
  task automatic push_frame(input logic [15:0] data, input logic m, input int unsigned p,
                            input logic [3:0] msk);
    logic [23:0] bits;
    exp_t        e;
    int          pp;
    logic        c;
    bits = {8'hA5, data};
    pp   = (p == 0) ? 1 : int'(p);
    for (int i = 23; i >= 0; i--) begin
      for (int h = 0; h < (m ? 2 : 1); h++) begin
        c = (h == 0) ? bits[i] : ~bits[i];
        for (int k = 0; k < pp; k++) begin
          e.heat = c ? msk : 4'b0000;
          e.busy = 1'b1;
          e.done = 1'b0;
          e.frames = '0;
          sbq.push_back(e);
        end
      end
    end
    for (int k = 0; k < 4 * pp; k++) begin
      e.heat = 4'b0000;
      e.busy = 1'b1;
      e.done = 1'b0;
      e.frames = '0;
      sbq.push_back(e);
    end
    model_frames++;
    e.heat = 4'b0000;
    e.busy = 1'b0;
    e.done = 1'b1;
    e.frames = 16'(model_frames);
    sbq.push_back(e);
  endtask

  task automatic send_frame(input logic [15:0] data, input logic m, input logic [PERIOD_W-1:0] p,
                            input logic [3:0] msk, input bit hold,
                            output int t_acc, output logic acc_done);
    int n;
    bus.s_data  = data;
    mode        = m;
    bit_period  = p;
    bank_mask   = msk;
    bus.s_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.s_ready && enable) && n < 500);
    if (!(bus.s_ready && enable)) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: s_ready=%0b after %0d cycles, required 1", bus.s_ready, n);
      t_acc = cyc;
      acc_done = 1'b0;
      bus.s_valid = 1'b0;
      return;
    end
    acc_done = done;
    push_frame(data, m, int'(p), msk);
    t_acc = cyc + 1;
    @(posedge clk);
    #1;
    if (!hold) bus.s_valid = 1'b0;
    // Scramble sampled-at-accept inputs; the frame in flight must ignore them.
    mode       = ~m;
    bit_period = 24'd7;
    bank_mask  = ~msk;
  endtask

  task automatic wait_done(input int t_acc, input int exp_lat, input string nm);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s: done never seen, required at latency %0d", nm, exp_lat);
    end else begin
      chk(nm, cyc - t_acc + 1, exp_lat);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int   t;
    int   tb2;
    logic ad;
    int   n;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    #12;
    chk("reset_s_ready", bus.s_ready, 0);
    chk("reset_heat_on", heat_on, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frames", frames_sent, 0);
    chk("reset_led", led, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("s_ready_before_first_edge", bus.s_ready, 0);
    @(posedge clk);
    #1 chk("s_ready_after_first_edge", bus.s_ready, 1);

    // OOK, P=3, two banks.
    send_frame(16'h00FF, 1'b0, 24'd3, 4'b0011, 1'b0, t, ad);
    wait_done(t, 85, "latency_ook_p3");

    // Manchester, P=2, all banks.
    send_frame(16'h8001, 1'b1, 24'd2, 4'b1111, 1'b0, t, ad);
    wait_done(t, 105, "latency_manchester_p2");

    // bit_period 0 behaves as 1.
    send_frame(16'hC3A5, 1'b0, 24'd0, 4'b1010, 1'b0, t, ad);
    wait_done(t, 29, "latency_period0");

    // Ten-cycle pause in the payload.
    send_frame(16'h5AF0, 1'b0, 24'd3, 4'b1100, 1'b0, t, ad);
    repeat (40) @(posedge clk);
    #1 enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("pause_s_ready", bus.s_ready, 0);
    repeat (5) @(posedge clk);
    #1 enable = 1'b1;
    wait_done(t, 95, "latency_with_pause");

    // Reset in the middle of the payload.
    send_frame(16'hFFFF, 1'b1, 24'd1, 4'b1111, 1'b0, t, ad);
    repeat (30) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_s_ready", bus.s_ready, 0);
    chk("midreset_heat_on", heat_on, 0);
    chk("midreset_heater_tap", heater_tap, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_frames", frames_sent, 0);
    chk("midreset_led", led, 0);
    sbq.delete();
    model_frames = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("release_s_ready_pre_edge", bus.s_ready, 0);
    @(posedge clk);
    #1 chk("release_s_ready", bus.s_ready, 1);
    send_frame(16'hA55A, 1'b0, 24'd2, 4'b1001, 1'b0, t, ad);
    wait_done(t, 57, "latency_after_reset");

    // s_valid held while busy with junk data; next word accepted in the done cycle.
    send_frame(16'h0F0F, 1'b0, 24'd1, 4'b0110, 1'b1, t, ad);
    n = 0;
    while (!done && n < 200) begin
      bus.s_data = 16'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_held_valid", cyc - t + 1, 29);
    send_frame(16'hF0F0, 1'b1, 24'd1, 4'b1111, 1'b0, tb2, ad);
    chk("accept_in_done_cycle", ad, 1);
    wait_done(tb2, 53, "latency_back_to_back");

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    chk("frames_final", frames_sent, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
